// File: rtl/uart_line_packer.sv
// ---------------------------------------------------------------------------
// UartLinePacker (module uart_line_packer)
//
// Packs the received UART byte stream into 1024-bit lines for the 64-line
// single-port image memory. Each completed (or flushed) line is written once
// at sequentially increasing word addresses. Once all DEPTH lines are written
// the frame is full: further bytes are dropped and flagged as overflow until
// a clear restarts the frame.
//
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   rx_data/valid     incoming UART byte and its valid flag
//   rx_ready          packer accepts a byte this cycle
//   flush             pulse: commit the partial line
//   clear             pulse: restart the frame at address 0
//   mem_*             registered single-port memory write interface
//   line_count        lines written in the current frame (0..DEPTH)
//   frame_done        all DEPTH lines written
//   overflow          sticky: a byte arrived while the frame was full
// ---------------------------------------------------------------------------
module uart_line_packer #(
   parameter int LINE_BYTES = 128,
   parameter int ADDR_W     = 6,
   parameter int DEPTH      = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   input  logic                    flush,
   input  logic                    clear,
   output logic [ADDR_W-1:0]       mem_address,
   output logic [LINE_BYTES-1:0]   mem_byteenable,
   output logic [8*LINE_BYTES-1:0] mem_writedata,
   output logic                    mem_chipselect,
   output logic                    mem_write,
   output logic                    mem_clken,
   output logic [ADDR_W:0]         line_count,
   output logic                    frame_done,
   output logic                    overflow
);

   localparam int CNT_W = $clog2(LINE_BYTES);

   typedef enum logic [1:0] {FILL, WRITE, FULL} stateT;

   stateT                    r_state;
   stateT                    w_nextState;
   logic [CNT_W-1:0]         r_byteCnt;
   logic [ADDR_W-1:0]        r_lineAddr;
   logic [ADDR_W:0]          r_lineCount;
   logic [8*LINE_BYTES-1:0]  r_buffer;
   logic [LINE_BYTES-1:0]    r_enables;
   logic                     r_overflow;
   logic                     r_memClken;
   logic                     r_memWrite;
   logic [ADDR_W-1:0]        r_memAddress;
   logic [LINE_BYTES-1:0]    r_memByteEnable;
   logic [8*LINE_BYTES-1:0]  r_memWriteData;

   logic                     w_rxReady;
   logic                     w_frameDone;
   logic                     w_accept;
   logic                     w_lastByte;
   logic                     w_goWrite;
   logic [CNT_W+2:0]         w_bitBase;
   logic [8*LINE_BYTES-1:0]  w_nextBuffer;
   logic [LINE_BYTES-1:0]    w_nextEnables;

   // A clear pulse blocks acceptance so the discarded line cannot pick up a byte.
   assign w_accept   = rx_valid & w_rxReady & ~clear;
   assign w_lastByte = (r_byteCnt == CNT_W'(LINE_BYTES - 1));
   assign w_goWrite  = (r_state == FILL) & ~clear &
                       ((w_accept & w_lastByte) | (flush & ((r_byteCnt != '0) | w_accept)));
   assign w_bitBase  = {r_byteCnt, 3'b000};

   // Line image including the byte accepted this cycle, so a line completed or
   // flushed together with a byte is written with that byte in place.
   always_comb begin
      w_nextBuffer  = r_buffer;
      w_nextEnables = r_enables;
      if (w_accept) begin
         w_nextBuffer[w_bitBase +: 8] = rx_data;
         w_nextEnables[r_byteCnt]     = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= FILL;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: WRITE always lasts exactly one cycle; the last line of
   // the frame parks the packer in FULL until cleared.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         FILL: begin
            if (w_goWrite) w_nextState = WRITE;
         end
         WRITE: begin
            if (clear)                                    w_nextState = FILL;
            else if (r_lineAddr == ADDR_W'(DEPTH - 1))    w_nextState = FULL;
            else                                          w_nextState = FILL;
         end
         FULL: begin
            if (clear) w_nextState = FILL;
         end
         default: w_nextState = FILL;
      endcase
   end

   // State-decoded outputs; rx_ready is held low while reset is asserted.
   always_comb begin
      w_rxReady   = reset_n & (r_state == FILL);
      w_frameDone = (r_state == FULL);
   end

   // Datapath: byte packing, line bookkeeping and the registered memory port.
   // The memory outputs are loaded on the edge that enters WRITE, so the write
   // strobe appears the cycle right after the final byte is accepted.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_byteCnt       <= '0;
         r_lineAddr      <= '0;
         r_lineCount     <= '0;
         r_buffer        <= '0;
         r_enables       <= '0;
         r_overflow      <= 1'b0;
         r_memClken      <= 1'b0;
         r_memWrite      <= 1'b0;
         r_memAddress    <= '0;
         r_memByteEnable <= '0;
         r_memWriteData  <= '0;
      end else begin
         r_memClken <= 1'b1;
         case (r_state)
            FILL: begin
               if (clear) begin
                  r_byteCnt   <= '0;
                  r_buffer    <= '0;
                  r_enables   <= '0;
                  r_lineAddr  <= '0;
                  r_lineCount <= '0;
                  r_overflow  <= 1'b0;
               end else if (w_goWrite) begin
                  r_memWrite      <= 1'b1;
                  r_memAddress    <= r_lineAddr;
                  r_memByteEnable <= w_nextEnables;
                  r_memWriteData  <= w_nextBuffer;
               end else if (w_accept) begin
                  r_buffer  <= w_nextBuffer;
                  r_enables <= w_nextEnables;
                  r_byteCnt <= r_byteCnt + CNT_W'(1);
               end
            end
            WRITE: begin
               r_memWrite <= 1'b0;
               r_byteCnt  <= '0;
               r_buffer   <= '0;
               r_enables  <= '0;
               if (clear) begin
                  r_lineAddr  <= '0;
                  r_lineCount <= '0;
                  r_overflow  <= 1'b0;
               end else begin
                  r_lineAddr  <= r_lineAddr + ADDR_W'(1);
                  r_lineCount <= r_lineCount + (ADDR_W + 1)'(1);
               end
            end
            FULL: begin
               if (clear) begin
                  r_lineAddr  <= '0;
                  r_lineCount <= '0;
                  r_overflow  <= 1'b0;
               end else if (rx_valid) begin
                  r_overflow <= 1'b1;
               end
            end
            default: r_memWrite <= 1'b0;
         endcase
      end
   end

   assign rx_ready       = w_rxReady;
   assign frame_done     = w_frameDone;
   assign overflow       = r_overflow;
   assign line_count     = r_lineCount;
   assign mem_clken      = r_memClken;
   assign mem_write      = r_memWrite;
   assign mem_chipselect = r_memWrite;
   assign mem_address    = r_memAddress;
   assign mem_byteenable = r_memByteEnable;
   assign mem_writedata  = r_memWriteData;

endmodule

// File: doc/uart_line_packer.md
Name: uart_line_packer

Overview:
- Sits directly upstream of the 64 x 1024-bit single-port on-chip image memory in the UART subsystem.
- Accepts the received UART byte stream and packs 128 consecutive bytes into one 1024-bit line.
- Writes each completed line into the memory at sequentially increasing word addresses, 0..63.
- Supports partial-line flush through per-byte enables, and reports frame completion and overflow to the coprocessor control.

Parameters:
- LINE_BYTES, 128, bytes per memory word; must equal the memory's byteenable width.
- ADDR_W, 6, memory address width.
- DEPTH, 64, number of memory lines per frame.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  packer can accept a byte this cycle.
- flush  in  1  single-cycle pulse; commit the partial line.
- clear  in  1  single-cycle pulse; restart the frame at address 0.
- mem_address  out  ADDR_W  memory word address.
- mem_byteenable  out  LINE_BYTES  per-byte write enable.
- mem_writedata  out  8*LINE_BYTES  line data.
- mem_chipselect  out  1  memory select.
- mem_write  out  1  memory write strobe.
- mem_clken  out  1  memory clock enable; constant 1 after reset.
- line_count  out  ADDR_W+1  number of lines written in the current frame, 0..64.
- frame_done  out  1  all DEPTH lines written.
- overflow  out  1  sticky; a byte was presented while the frame was full.

Behaviour:
- Reset: sampled on the rising clk edge while reset_n=0. It forces:
  - state=FILL;
  - byte_cnt=0, line_addr=0, line_count=0;
  - byte buffer=0 and enable accumulator=0;
  - mem_chipselect=0, mem_write=0, mem_byteenable=0, mem_writedata=0, mem_address=0, mem_clken=0;
  - frame_done=0, overflow=0, rx_ready=0.
- Reset mid-write aborts the write; no partial memory state is tracked.
- Handshake: a byte transfers on a cycle where rx_valid=1 and rx_ready=1. rx_ready=1 only in state FILL and not during reset.
- Byte placement: the k-th accepted byte of a line (k=0..127) goes to buffer bits [8k+7:8k] and sets enable bit k. Bytes that were never written stay 0.
- FILL state:
  - Each accepted byte increments byte_cnt.
  - Accepting byte k=127 -> WRITE on the next cycle.
  - flush=1 with byte_cnt>0, or with a byte accepted in the same cycle -> WRITE; that byte is included in the line.
  - flush with an empty line and no byte accepted is ignored.
- WRITE state (exactly one cycle, all mem_* outputs registered):
  - mem_chipselect=1, mem_write=1, mem_address=line_addr;
  - mem_byteenable=accumulator, mem_writedata=buffer;
  - rx_ready=0.
  - Next cycle: mem_chipselect/mem_write=0; buffer, accumulator and byte_cnt clear; line_count+1; line_addr+1.
  - If line_addr was DEPTH-1 -> FULL (line_addr wraps to 0); otherwise -> FILL.
- Latency: the final byte is accepted at cycle N and mem_write=1 at cycle N+1. The first byte of the next line can be accepted at N+2.
- FULL state:
  - frame_done=1, rx_ready=0.
  - Any rx_valid=1 sets overflow (sticky); the byte is dropped.
  - flush is ignored.
- clear:
  - In FILL: discard the partial line, line_addr=0, line_count=0, overflow=0, frame_done=0; stay in FILL.
  - In WRITE: the write in progress completes; the next state is FILL with address 0 and counters cleared.
  - In FULL: go to FILL with everything cleared.
  - clear takes priority over flush and over byte acceptance in the same cycle; no byte is accepted.
- mem_chipselect and mem_write never assert outside WRITE. mem_address is stable for the whole write cycle.

Test Plan:
- Reset then stream 128 bytes 0x00..0x7F -> one write cycle with mem_address=0, byteenable all-ones, writedata[7:0]=0x00 and [1023:1016]=0x7F; line_count=1.
- 5 bytes 0xA1..0xA5 then a flush pulse -> write with byteenable=0x1F, writedata[39:0]=0xA5A4A3A2A1, upper bits 0; next line starts at address 1.
- 64 full lines -> addresses 0..63 in order; frame_done=1 and rx_ready=0 after the 64th write. A further rx_valid sets overflow=1 and no write occurs.
- clear pulse in FULL -> frame_done=0, overflow=0, line_count=0; the next full line writes to address 0.
- Hold rx_valid=1 continuously -> rx_ready is low for exactly 1 cycle per line (the WRITE cycle); 256 bytes take 258 cycles.
- Drive reset_n low during the WRITE cycle -> mem_write=0 on the next cycle; all outputs hold reset values; the next line writes to address 0.
